hazard_unit: RTL and testbench

- Pipeline hazard tracker directly downstream of the destination-register decoder in the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Consumes the decoded destination register of the instruction in ID and carries it through EX/MEM/WB shadow registers.
- Raises a load-use stall for ID and produces EX-stage operand forwarding selects.
- Also freezes the pipeline on data-memory wait and counts lost cycles.

---
 rtl/hazard_unit_pkg.sv | 67 ++++++
 rtl/hazard_src_decode.sv | 35 +++
 rtl/hazard_unit.sv | 101 ++++++++++
 tb/tb_hazard_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared MIPS ISA constants, instruction field positions and pipeline shadow payloads
// for the hazard tracker.
package hazard_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned FWD_W   = 2;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_LSB  = 16;

    typedef logic [REG_W-1:0] reg_t;
    typedef logic [OPC_W-1:0] opc_t;
    typedef logic [FWD_W-1:0] fwd_t;

    localparam opc_t OPC_SPECIAL = 6'h00;
    localparam opc_t OPC_REGIMM  = 6'h01;
    localparam opc_t OPC_J       = 6'h02;
    localparam opc_t OPC_JAL     = 6'h03;
    localparam opc_t OPC_BEQ     = 6'h04;
    localparam opc_t OPC_BNE     = 6'h05;
    localparam opc_t OPC_BLEZ    = 6'h06;
    localparam opc_t OPC_BGTZ    = 6'h07;
    localparam opc_t OPC_ADDI    = 6'h08;
    localparam opc_t OPC_ADDIU   = 6'h09;
    localparam opc_t OPC_SLTI    = 6'h0A;
    localparam opc_t OPC_SLTIU   = 6'h0B;
    localparam opc_t OPC_ANDI    = 6'h0C;
    localparam opc_t OPC_ORI     = 6'h0D;
    localparam opc_t OPC_XORI    = 6'h0E;
    localparam opc_t OPC_LUI     = 6'h0F;
    localparam opc_t OPC_LB      = 6'h20;
    localparam opc_t OPC_LH      = 6'h21;
    localparam opc_t OPC_LW      = 6'h23;
    localparam opc_t OPC_LBU     = 6'h24;
    localparam opc_t OPC_LHU     = 6'h25;
    localparam opc_t OPC_SB      = 6'h28;
    localparam opc_t OPC_SH      = 6'h29;
    localparam opc_t OPC_SW      = 6'h2B;

    localparam logic [5:0] FUN_SLL = 6'h00;
    localparam logic [5:0] FUN_JR  = 6'h08;
    localparam logic [5:0] FUN_ADD = 6'h20;
    localparam logic [5:0] FUN_SUB = 6'h22;

    localparam reg_t RT_BLTZ = 5'h00;
    localparam reg_t RT_BGEZ = 5'h01;

    localparam fwd_t FWD_RF  = 2'b00;
    localparam fwd_t FWD_MEM = 2'b01;
    localparam fwd_t FWD_WB  = 2'b10;

    // EX shadow: destination, load flag and the sources actually read
    typedef struct packed {
        reg_t dst;
        logic ld;
        reg_t rs;
        reg_t rt;
    } ex_stage_t;

    typedef struct packed {
        reg_t dst;
        logic ld;
    } mem_stage_t;

endpackage

// File: rtl/hazard_src_decode.sv
// Opcode-only decode of which source registers an instruction reads and whether it loads.
module hazard_src_decode
    import hazard_unit_pkg::*;
(
    input  opc_t opc,
    output logic uses_rs,
    output logic uses_rt,
    output logic is_load
);

    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_load = 1'b0;
        case (opc)
            // SPECIAL is treated as reading rt even for JR and shifts
            OPC_SPECIAL, OPC_BEQ, OPC_BNE, OPC_SB, OPC_SH, OPC_SW: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OPC_REGIMM, OPC_BLEZ, OPC_BGTZ, OPC_ADDI, OPC_ADDIU,
            OPC_SLTI, OPC_SLTIU, OPC_ANDI, OPC_ORI, OPC_XORI: begin
                uses_rs = 1'b1;
            end
            OPC_LB, OPC_LBU, OPC_LH, OPC_LHU, OPC_LW: begin
                uses_rs = 1'b1;
                is_load = 1'b1;
            end
            default: begin
                uses_rs = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall, EX operand forwarding and memory-wait freeze for the 5-stage MIPS pipe,
// with a saturating count of lost cycles.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  id_instruction,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_write_reg,
    input  logic             mem_ready,
    input  logic             flush,
    output logic             stall,
    output logic             freeze,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b,
    output logic [CNT_W-1:0] stall_cycles
);

    ex_stage_t  ex_q;
    ex_stage_t  ex_nxt;
    mem_stage_t mem_q;
    reg_t       wb_dst;

    opc_t id_opc;
    reg_t id_rs;
    reg_t id_rt;
    logic uses_rs;
    logic uses_rt;
    logic is_load;
    logic hazard;
    logic unused_imm;

    assign id_opc     = id_instruction[OPC_LSB +: OPC_W];
    assign id_rs      = id_instruction[RS_LSB +: REG_W];
    assign id_rt      = id_instruction[RT_LSB +: REG_W];
    assign unused_imm = ^id_instruction[RT_LSB-1:0];

    hazard_src_decode u_decode (
        .opc     (id_opc),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt),
        .is_load (is_load)
    );

    // A load in EX whose destination is read by ID cannot forward in time
    assign hazard = id_valid & ex_q.ld & (ex_q.dst != '0)
                  & ((uses_rs & (id_rs == ex_q.dst)) | (uses_rt & (id_rt == ex_q.dst)));
    assign stall  = hazard & ~flush & mem_ready;
    assign freeze = ~mem_ready;

    always_comb begin
        ex_nxt = '0;
        if (!(stall | flush | ~id_valid)) begin
            ex_nxt.dst = id_write_reg;
            ex_nxt.ld  = is_load;
            ex_nxt.rs  = uses_rs ? id_rs : '0;
            ex_nxt.rt  = uses_rt ? id_rt : '0;
        end
    end

    // MEM wins over WB; a load result in MEM is never a legal forward source
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if ((ex_q.rs != '0) && (ex_q.rs == mem_q.dst) && !mem_q.ld) begin
            fwd_a = FWD_MEM;
        end else if ((ex_q.rs != '0) && (ex_q.rs == wb_dst)) begin
            fwd_a = FWD_WB;
        end
        if ((ex_q.rt != '0) && (ex_q.rt == mem_q.dst) && !mem_q.ld) begin
            fwd_b = FWD_MEM;
        end else if ((ex_q.rt != '0) && (ex_q.rt == wb_dst)) begin
            fwd_b = FWD_WB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q   <= '0;
            mem_q  <= '0;
            wb_dst <= '0;
        end else if (mem_ready) begin
            wb_dst    <= mem_q.dst;
            mem_q.dst <= ex_q.dst;
            mem_q.ld  <= ex_q.ld;
            ex_q      <= ex_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if ((stall | freeze) && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit: expectations are queued with each stimulus
// step and drained when the outputs are sampled on the falling edge.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_instruction;
    logic        id_valid;
    logic [4:0]  id_write_reg;
    logic        mem_ready;
    logic        flush;
    logic        stall;
    logic        freeze;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] stall_cycles;
    logic        unused_stall_s;
    logic        unused_freeze_s;
    logic [1:0]  unused_fwd_a_s;
    logic [1:0]  unused_fwd_b_s;
    logic [1:0]  cnt_s;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_instruction(id_instruction), .id_valid(id_valid),
        .id_write_reg(id_write_reg), .mem_ready(mem_ready), .flush(flush),
        .stall(stall), .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cycles(stall_cycles)
    );

    // Narrow counter instance to reach saturation quickly
    hazard_unit #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_instruction(id_instruction), .id_valid(id_valid),
        .id_write_reg(id_write_reg), .mem_ready(mem_ready), .flush(flush),
        .stall(unused_stall_s), .freeze(unused_freeze_s), .fwd_a(unused_fwd_a_s),
        .fwd_b(unused_fwd_b_s), .stall_cycles(cnt_s)
    );

    typedef enum {S_STALL, S_FREEZE, S_FWDA, S_FWDB, S_CNT, S_CNT2} sig_e;
    typedef struct {
        sig_e        sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void want(sig_e s, int unsigned v, string tag);
        exp_t e;
        e.sig = s;
        e.val = v;
        e.tag = tag;
        exp_q.push_back(e);
    endfunction

    task automatic check_now();
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] obs;
            e = exp_q.pop_front();
            case (e.sig)
                S_STALL:  obs = 32'(stall);
                S_FREEZE: obs = 32'(freeze);
                S_FWDA:   obs = 32'(fwd_a);
                S_FWDB:   obs = 32'(fwd_b);
                S_CNT:    obs = stall_cycles;
                default:  obs = 32'(cnt_s);
            endcase
            tests++;
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive(logic [31:0] ins, logic v, logic [4:0] wr, logic mr, logic fl);
        id_instruction = ins;
        id_valid       = v;
        id_write_reg   = wr;
        mem_ready      = mr;
        flush          = fl;
    endtask

    task automatic step(logic [31:0] ins, logic v, logic [4:0] wr, logic mr, logic fl);
        drive(ins, v, wr, mr, fl);
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        step(32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) nop();
    endtask

    function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                          logic [5:0] fn);
        return {OPC_SPECIAL, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(opc_t op, logic [4:0] rs, logic [4:0] rt,
                                          logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] lw8, add10, beq89;
        lw8   = itype(OPC_LW, 5'd9, 5'd8, 16'd0);
        add10 = rtype(5'd8, 5'd11, 5'd10, FUN_ADD);
        beq89 = itype(OPC_BEQ, 5'd8, 5'd9, 16'd4);

        rst_n = 1'b0;
        drive(32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        #12;
        want(S_STALL, 0, "rst_stall");
        want(S_FREEZE, 0, "rst_freeze");
        want(S_FWDA, 0, "rst_fwda");
        want(S_FWDB, 0, "rst_fwdb");
        want(S_CNT, 0, "rst_cnt");
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // load-use: one stall cycle, then WB forward
        want(S_STALL, 0, "t1_lw_nostall");
        step(lw8, 1'b1, 5'd8, 1'b1, 1'b0);
        want(S_STALL, 1, "t1_stall");
        want(S_FWDA, 0, "t1_lw_fwda");
        want(S_CNT, 0, "t1_cnt_before");
        step(add10, 1'b1, 5'd10, 1'b1, 1'b0);
        want(S_STALL, 0, "t1_stall_once");
        want(S_CNT, 1, "t1_cnt");
        want(S_CNT2, 1, "t1_cnt_s");
        step(add10, 1'b1, 5'd10, 1'b1, 1'b0);
        want(S_FWDA, 2, "t1_fwda_wb");
        want(S_FWDB, 0, "t1_fwdb_rf");
        nop();
        drain();

        // ALU result forwarded from MEM with no stall
        want(S_STALL, 0, "t2_addi_stall");
        step(itype(OPC_ADDI, 5'd0, 5'd8, 16'd5), 1'b1, 5'd8, 1'b1, 1'b0);
        want(S_STALL, 0, "t2_sub_stall");
        step(rtype(5'd11, 5'd8, 5'd12, FUN_SUB), 1'b1, 5'd12, 1'b1, 1'b0);
        want(S_FWDA, 0, "t2_fwda_rf");
        want(S_FWDB, 1, "t2_fwdb_mem");
        want(S_CNT, 1, "t2_cnt");
        nop();
        drain();

        // $0 is never forwarded
        want(S_STALL, 0, "t3_addi0_stall");
        step(itype(OPC_ADDI, 5'd0, 5'd0, 16'd1), 1'b1, 5'd0, 1'b1, 1'b0);
        want(S_STALL, 0, "t3_add_stall");
        step(rtype(5'd0, 5'd0, 5'd3, FUN_ADD), 1'b1, 5'd3, 1'b1, 1'b0);
        want(S_FWDA, 0, "t3_fwda_r0");
        want(S_FWDB, 0, "t3_fwdb_r0");
        nop();
        drain();

        // memory wait freezes a pending load-use pair
        want(S_CNT, 1, "t4_cnt_start");
        step(lw8, 1'b1, 5'd8, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            want(S_FREEZE, 1, "t4_freeze");
            want(S_STALL, 0, "t4_stall_frozen");
            want(S_CNT, 32'(1 + i), "t4_cnt_frozen");
            want(S_CNT2, (1 + i > 3) ? 3 : 32'(1 + i), "t4_cnt_s_frozen");
            step(add10, 1'b1, 5'd10, 1'b0, 1'b0);
        end
        want(S_FREEZE, 0, "t4_release");
        want(S_STALL, 1, "t4_stall_after");
        want(S_CNT, 4, "t4_cnt_release");
        want(S_CNT2, 3, "t4_cnt_s_sat");
        step(add10, 1'b1, 5'd10, 1'b1, 1'b0);
        want(S_STALL, 0, "t4_stall_done");
        want(S_CNT, 5, "t4_cnt_final");
        want(S_CNT2, 3, "t4_cnt_s_hold");
        step(add10, 1'b1, 5'd10, 1'b1, 1'b0);
        want(S_FWDA, 2, "t4_fwda_wb");
        nop();
        drain();

        // flush beats the hazard
        step(lw8, 1'b1, 5'd8, 1'b1, 1'b0);
        want(S_STALL, 0, "t5_flush_nostall");
        want(S_CNT, 5, "t5_cnt");
        step(beq89, 1'b1, 5'd0, 1'b1, 1'b1);
        want(S_FWDA, 0, "t5_fwda");
        want(S_FWDB, 0, "t5_fwdb");
        want(S_CNT, 5, "t5_cnt_after");
        nop();
        drain();

        // asynchronous reset with live shadows
        step(itype(OPC_ADDI, 5'd0, 5'd7, 16'd1), 1'b1, 5'd7, 1'b1, 1'b0);
        step(itype(OPC_ADDI, 5'd0, 5'd6, 16'd2), 1'b1, 5'd6, 1'b1, 1'b0);
        step(itype(OPC_LW, 5'd7, 5'd5, 16'd0), 1'b1, 5'd5, 1'b1, 1'b0);
        drive(rtype(5'd5, 5'd6, 5'd9, FUN_ADD), 1'b1, 5'd9, 1'b1, 1'b0);
        @(negedge clk);
        want(S_STALL, 1, "t6_pre_stall");
        want(S_FWDA, 2, "t6_pre_fwda");
        want(S_FWDB, 0, "t6_pre_fwdb");
        want(S_CNT, 5, "t6_pre_cnt");
        check_now();
        rst_n = 1'b0;
        #1;
        want(S_STALL, 0, "t6_rst_stall");
        want(S_FWDA, 0, "t6_rst_fwda");
        want(S_FWDB, 0, "t6_rst_fwdb");
        want(S_CNT, 0, "t6_rst_cnt");
        want(S_CNT2, 0, "t6_rst_cnt_s");
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        want(S_STALL, 0, "t6_post_stall");
        step(rtype(5'd5, 5'd6, 5'd9, FUN_ADD), 1'b1, 5'd9, 1'b1, 1'b0);
        want(S_FWDA, 0, "t6_post_fwda");
        want(S_FWDB, 0, "t6_post_fwdb");
        want(S_CNT, 0, "t6_post_cnt");
        nop();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
